// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI/host RAM arbiter.
//   arb_state_e : arbiter FSM states
//   req_e       : requester identity (used for round-robin bookkeeping)
//   CMD_*       : SPI command codes carried in rx_data[9:8]
package spi_ram_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RD_WAIT
  } arb_state_e;

  typedef enum logic {
    REQ_SPI,
    REQ_HOST
  } req_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Single-port RAM bus between the arbiter (master) and the RAM (slave).
//   en    : access enable, one cycle per access
//   we    : 1 = write, 0 = read
//   addr  : access address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access
interface spi_ram_arbiter_if;
  import spi_ram_pkg::*;

  logic                 en;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [7:0]           wdata;
  logic [7:0]           rdata;

  modport master (output en, output we, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/spi_ram_arbiter_spi_cmd_capture.sv
// SPI command decoder: keeps the write/read address registers and a single
// pending RAM operation for the arbiter.
//   rx_data/rx_valid : SPI command word and strobe
//   pend_clr         : arbiter is finishing the pending SPI access this cycle
//   pend*            : pending op flag, direction, address, write data
//   ovf              : sticky, a data command was dropped because one was pending
module spi_cmd_capture
  import spi_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 pend_clr,
  output logic                 pend,
  output logic                 pend_we,
  output logic [ADDR_SIZE-1:0] pend_addr,
  output logic [7:0]           pend_wdata,
  output logic                 ovf
);

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [1:0]           cmd;
  logic [7:0]           payload;
  logic                 busy;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];
  // A pending op that retires on this edge frees the slot for a new command.
  assign busy    = pend && !pend_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      ovf        <= 1'b0;
    end else begin
      if (pend_clr) pend <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload;
          CMD_RD_ADDR: rd_addr <= payload;
          CMD_WR_DATA: begin
            if (busy) ovf <= 1'b1;
            else begin
              pend       <= 1'b1;
              pend_we    <= 1'b1;
              pend_addr  <= wr_addr;
              pend_wdata <= payload;
            end
          end
          CMD_RD_DATA: begin
            if (busy) ovf <= 1'b1;
            else begin
              pend      <= 1'b1;
              pend_we   <= 1'b0;
              pend_addr <= rd_addr;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one RAM port between SPI commands and a host requester, round-robin.
//   clk, rst            : clock, async active-high reset
//   spi_rx_data/valid   : SPI command in;  spi_tx_data/valid : SPI read data out
//   spi_ovf             : sticky SPI command overflow
//   host_req/we/addr/wdata : host request (held until host_gnt)
//   host_gnt            : host access performed this cycle
//   host_rdata/rvalid   : host read data out
//   ram                 : RAM bus (registered outputs)
module spi_ram_arbiter
  import spi_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [7:0]           spi_tx_data,
  output logic                 spi_tx_valid,
  output logic                 spi_ovf,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  spi_ram_arbiter_if.master    ram
);

  arb_state_e           state_q, state_d;
  req_e                 last_gnt, winner;
  logic                 grant;
  logic                 spi_pend, spi_pend_we, pend_clr;
  logic [ADDR_SIZE-1:0] spi_pend_addr;
  logic [7:0]           spi_pend_wdata;

  // last_gnt doubles as the owner of the access currently in flight.
  assign pend_clr = (state_q == ACC) && (last_gnt == REQ_SPI);

  spi_cmd_capture u_cmd (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (spi_rx_data),
    .rx_valid   (spi_rx_valid),
    .pend_clr   (pend_clr),
    .pend       (spi_pend),
    .pend_we    (spi_pend_we),
    .pend_addr  (spi_pend_addr),
    .pend_wdata (spi_pend_wdata),
    .ovf        (spi_ovf)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = REQ_SPI;
    case (state_q)
      IDLE: begin
        if (spi_pend && host_req) begin
          grant  = 1'b1;
          winner = (last_gnt == REQ_SPI) ? REQ_HOST : REQ_SPI;
        end else if (spi_pend) begin
          grant = 1'b1;
        end else if (host_req) begin
          grant  = 1'b1;
          winner = REQ_HOST;
        end
        if (grant) state_d = ACC;
      end
      ACC:     state_d = ram.we ? IDLE : RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_gnt     <= REQ_HOST;
      ram.en       <= 1'b0;
      ram.we       <= 1'b0;
      ram.addr     <= '0;
      ram.wdata    <= '0;
      host_gnt     <= 1'b0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      spi_tx_data  <= '0;
      spi_tx_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram.en       <= grant;
      host_gnt     <= grant && (winner == REQ_HOST);
      host_rvalid  <= 1'b0;
      spi_tx_valid <= 1'b0;
      if (grant) begin
        last_gnt <= winner;
        if (winner == REQ_HOST) begin
          ram.we    <= host_we;
          ram.addr  <= host_addr;
          ram.wdata <= host_wdata;
        end else begin
          ram.we    <= spi_pend_we;
          ram.addr  <= spi_pend_addr;
          ram.wdata <= spi_pend_wdata;
        end
      end
      if (state_q == RD_WAIT) begin
        if (last_gnt == REQ_HOST) begin
          host_rdata  <= ram.rdata;
          host_rvalid <= 1'b1;
        end else begin
          spi_tx_data  <= ram.rdata;
          spi_tx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       spi_ovf;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;

  spi_ram_arbiter_if ram_bus ();

  spi_ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .spi_ovf      (spi_ovf),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .ram          (ram_bus)
  );

  always #5 clk = ~clk;

  // RAM attached to the bus, plus the reference memory content.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  always @(posedge clk) begin
    if (ram_bus.en) begin
      if (ram_bus.we) mem[ram_bus.addr] <= ram_bus.wdata;
      else ram_bus.rdata <= mem[ram_bus.addr];
    end
  end

  int total = 0;
  int bad = 0;

  op_t        spi_q[$];
  op_t        host_q[$];
  logic [7:0] spi_rd_q[$];
  logic [7:0] host_rd_q[$];
  logic [7:0] m_wr, m_rd;
  bit         log_en = 0;
  bit         win_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM access must be the oldest outstanding op of its owner.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_bus.en) begin
        op_t e;
        bit  have;
        have = 1'b0;
        if (host_gnt) begin
          if (host_q.size() == 0) chk("unexpected_host_access", ram_bus.en, 0);
          else begin e = host_q.pop_front(); have = 1'b1; end
        end else begin
          if (spi_q.size() == 0) chk("unexpected_spi_access", ram_bus.en, 0);
          else begin e = spi_q.pop_front(); have = 1'b1; end
        end
        if (have) begin
          chk(host_gnt ? "host_acc_we" : "spi_acc_we", ram_bus.we, e.we);
          chk(host_gnt ? "host_acc_addr" : "spi_acc_addr", ram_bus.addr, e.addr);
          if (e.we) begin
            chk(host_gnt ? "host_acc_wdata" : "spi_acc_wdata", ram_bus.wdata, e.data);
            ref_mem[e.addr] = e.data;
          end else if (host_gnt) host_rd_q.push_back(ref_mem[e.addr]);
          else spi_rd_q.push_back(ref_mem[e.addr]);
        end
        if (log_en) win_log.push_back(host_gnt);
      end
      if (host_gnt && !ram_bus.en) chk("host_gnt_without_access", host_gnt, 0);
      if (spi_tx_valid && host_rvalid) chk("tx_rvalid_overlap", host_rvalid, 0);
      if (spi_tx_valid) begin
        if (spi_rd_q.size() == 0) chk("unexpected_spi_tx_valid", spi_tx_valid, 0);
        else chk("spi_tx_data", spi_tx_data, spi_rd_q.pop_front());
      end
      if (host_rvalid) begin
        if (host_rd_q.size() == 0) chk("unexpected_host_rvalid", host_rvalid, 0);
        else chk("host_rdata", host_rdata, host_rd_q.pop_front());
      end
    end
  end

  // Called on a negedge; strobe spans the next rising edge; returns one negedge later.
  task automatic spi_send(input logic [1:0] cmd, input logic [7:0] pl, input bit drop = 0);
    spi_rx_data  = {cmd, pl};
    spi_rx_valid = 1'b1;
    case (cmd)
      2'b00: m_wr = pl;
      2'b10: m_rd = pl;
      2'b01: if (!drop) spi_q.push_back('{1'b1, m_wr, pl});
      2'b11: if (!drop) spi_q.push_back('{1'b0, m_rd, 8'h00});
    endcase
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  task automatic host_op(input logic we, input logic [7:0] addr, input logic [7:0] data);
    int n;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = data;
    host_q.push_back('{we, addr, data});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_gnt && n < 100);
    chk("host_gnt_timeout", host_gnt, 1);
    host_req = 1'b0;
  endtask

  task automatic wait_spi_free();
    int n;
    n = 0;
    while (spi_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("spi_slot_timeout", spi_q.size(), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((spi_q.size() + host_q.size() + spi_rd_q.size() + host_rd_q.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", spi_q.size() + host_q.size() + spi_rd_q.size() + host_rd_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {ram_bus.en, ram_bus.we, ram_bus.addr, ram_bus.wdata, spi_tx_data, spi_tx_valid,
               spi_ovf, host_gnt, host_rdata, host_rvalid}, 0);
  endtask

  // Called on a negedge: asserts reset, drops all outstanding expectations.
  task automatic do_reset();
    rst = 1'b1;
    spi_q.delete();
    host_q.delete();
    spi_rd_q.delete();
    host_rd_q.delete();
    m_wr = 8'h00;
    m_rd = 8'h00;
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, spi_cnt;
    logic [1:0] r_cmd;
    rst = 1'b1;
    spi_rx_data = '0;
    spi_rx_valid = 1'b0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    m_wr = 8'h00;
    m_rd = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check_outputs_zero("initial_reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // 1: write 0xA5 to 0x12, access two cycles after the data strobe
    spi_send(2'b00, 8'h12);
    spi_send(2'b01, 8'hA5);
    chk("t1_en_early", ram_bus.en, 0);
    @(negedge clk);
    chk("t1_en", ram_bus.en, 1);
    chk("t1_we", ram_bus.we, 1);
    chk("t1_addr", ram_bus.addr, 8'h12);
    chk("t1_wdata", ram_bus.wdata, 8'hA5);
    repeat (2) @(negedge clk);

    // 2: read back 0x12, tx_valid four cycles after the strobe
    spi_send(2'b10, 8'h12);
    spi_send(2'b11, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t2_tx_valid_early", spi_tx_valid, 0);
    @(negedge clk);
    chk("t2_tx_valid", spi_tx_valid, 1);
    chk("t2_tx_data", spi_tx_data, 8'hA5);
    @(negedge clk);
    chk("t2_tx_valid_one_cycle", spi_tx_valid, 0);
    wait_idle();

    // 3: after reset SPI wins the first tie, host follows
    do_reset();
    spi_send(2'b00, 8'h20);
    spi_send(2'b01, 8'h99);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h40;
    host_wdata = 8'h3C;
    host_q.push_back('{1'b1, 8'h40, 8'h3C});
    @(negedge clk);
    chk("t3_spi_first_en", ram_bus.en, 1);
    chk("t3_spi_first_gnt", host_gnt, 0);
    chk("t3_spi_first_addr", ram_bus.addr, 8'h20);
    @(negedge clk);
    @(negedge clk);
    chk("t3_host_gnt", host_gnt, 1);
    chk("t3_host_addr", ram_bus.addr, 8'h40);
    host_req = 1'b0;
    wait_idle();
    chk("t3_ram_40", mem[8'h40], 8'h3C);

    // 4: continuous host reads vs periodic SPI writes must alternate
    win_log.delete();
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 12; i++) host_op(1'b0, 8'($urandom), 8'h00);
      end
      begin
        spi_send(2'b00, 8'h60);
        for (int j = 0; j < 6; j++) begin
          wait_spi_free();
          spi_send(2'b01, 8'(j + 1));
          repeat (2) @(negedge clk);
        end
      end
    join
    wait_idle();
    log_en = 0;
    first = -1;
    last = -1;
    spi_cnt = 0;
    for (int i = 0; i < win_log.size(); i++) begin
      if (!win_log[i]) begin
        if (first < 0) first = i;
        last = i;
        spi_cnt++;
      end
    end
    chk("t4_spi_grants", spi_cnt, 6);
    for (int i = first; i >= 0 && i < last; i++)
      chk("t4_no_back_to_back_host", win_log[i] && win_log[i+1], 0);

    // 5: second data command while one is pending is dropped, ovf sticky
    spi_send(2'b00, 8'h55);
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 8'h07;
    host_q.push_back('{1'b0, 8'h07, 8'h00});
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!host_gnt && n < 100);
      chk("t5_host_gnt", host_gnt, 1);
    end
    host_req = 1'b0;
    spi_send(2'b01, 8'h77);
    @(negedge clk);
    chk("t5_ovf_before", spi_ovf, 0);
    spi_send(2'b01, 8'h88, 1);
    chk("t5_ovf_set", spi_ovf, 1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("t5_ovf_sticky", spi_ovf, 1);
    chk("t5_ram_55", mem[8'h55], 8'h77);

    // 6: reset during RD_WAIT of an SPI read discards it
    spi_send(2'b10, 8'h12);
    spi_send(2'b11, 8'h00);
    @(negedge clk);
    chk("t6_acc", ram_bus.en, 1);
    @(negedge clk);
    do_reset();
    repeat (6) @(negedge clk);
    spi_send(2'b11, 8'hFF);
    repeat (3) @(negedge clk);
    chk("t6_read_addr0_valid", spi_tx_valid, 1);
    wait_idle();

    // Random mixed traffic, data commands issued only when the SPI slot is free
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          r_cmd = 2'($urandom_range(0, 3));
          if (r_cmd[0]) wait_spi_free();
          spi_send(r_cmd, 8'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          host_op(1'($urandom), 8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
    join
    wait_idle();
    chk("rand_no_ovf", spi_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
